// File: rtl/hw0_response_checker.sv
// Response checker for the HW0 four-input vector sequence: compares P against a golden table,
// tracks errors, first failure and coverage. Optional MISR signature under `RESP_SIGNATURE_EN.
module hw0_response_checker #(
  parameter logic [15:0] EXPECT_TABLE     = 16'hEEE0,
  parameter int unsigned NUM_VECTORS      = 16,
  parameter int unsigned REQUIRE_FULL_COV = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Vld,
  input  logic        H1,
  input  logic        H2,
  input  logic        B1,
  input  logic        B2,
  input  logic        P,
  output logic        Busy,
  output logic        Done,
  output logic        Pass,
  output logic [4:0]  ErrCnt,
  output logic        FirstFailVld,
  output logic [3:0]  FirstFailVec,
  output logic [15:0] CovMask,
  output logic [15:0] Signature
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [7:0] NUM_V = 8'(NUM_VECTORS);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  err_q, err_d;
  logic        ffv_q, ffv_d;
  logic [3:0]  ffvec_q, ffvec_d;
  logic [15:0] cov_q, cov_d;
  logic        pass_q, pass_d;

  logic [3:0] idx;
  logic       mismatch;
  logic       accept;

  assign idx      = {H1, H2, B1, B2};
  assign mismatch = (P != EXPECT_TABLE[idx]);
  assign accept   = !Start && (state_q == S_RUN) && Vld;

  // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    cov_d   = cov_q;
    pass_d  = pass_q;

    if (Start) begin
      state_d = S_RUN;
      cnt_d   = '0;
      err_d   = '0;
      ffv_d   = 1'b0;
      ffvec_d = '0;
      cov_d   = '0;
      pass_d  = 1'b0;
    end else if (accept) begin
      cov_d = cov_q | (16'h0001 << idx);
      cnt_d = cnt_q + 8'd1;
      if (mismatch) begin
        err_d = (err_q == 5'd31) ? err_q : err_q + 5'd1;
        if (!ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = idx;
        end
      end
      // Pass uses the post-sample values so the final vector counts.
      if (cnt_d == NUM_V) begin
        state_d = S_DONE;
        pass_d  = (err_d == 5'd0) &&
                  ((REQUIRE_FULL_COV == 0) || (cov_d == 16'hFFFF));
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; async reset clears everything, including mid-run.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      cov_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      cov_q   <= cov_d;
      pass_q  <= pass_d;
    end
  end

`ifdef RESP_SIGNATURE_EN
  logic [15:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (Start) begin
      sig_d = 16'hFFFF;
    end else if (accept) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ {11'b0, idx, P};
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign Signature = sig_q;
`else
  assign Signature = 16'h0000;
`endif

  assign Busy         = (state_q == S_RUN);
  assign Done         = (state_q == S_DONE);
  assign Pass         = pass_q;
  assign ErrCnt       = err_q;
  assign FirstFailVld = ffv_q;
  assign FirstFailVec = ffvec_q;
  assign CovMask      = cov_q;

endmodule

// File: tb/tb_hw0_response_checker.sv
// Directed bench for hw0_response_checker: default instance plus no-coverage and 40-sample variants.
module tb_hw0_response_checker;

`ifdef RESP_SIGNATURE_EN
  localparam bit SIG_EN = 1'b1;
`else
  localparam bit SIG_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic Start = 1'b0, Vld = 1'b0, H1 = 1'b0, H2 = 1'b0, B1 = 1'b0, B2 = 1'b0, P = 1'b0;

  logic        busy_a, done_a, pass_a, ffv_a;
  logic [4:0]  err_a;
  logic [3:0]  ffvec_a;
  logic [15:0] cov_a, sig_a;

  logic        busy_b, done_b, pass_b, ffv_b;
  logic [4:0]  err_b;
  logic [3:0]  ffvec_b;
  logic [15:0] cov_b, sig_b;

  logic        busy_c, done_c, pass_c, ffv_c;
  logic [4:0]  err_c;
  logic [3:0]  ffvec_c;
  logic [15:0] cov_c, sig_c;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  hw0_response_checker dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Vld(Vld), .H1(H1), .H2(H2), .B1(B1), .B2(B2), .P(P),
    .Busy(busy_a), .Done(done_a), .Pass(pass_a), .ErrCnt(err_a), .FirstFailVld(ffv_a),
    .FirstFailVec(ffvec_a), .CovMask(cov_a), .Signature(sig_a)
  );

  hw0_response_checker #(.REQUIRE_FULL_COV(0)) dut_nocov (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Vld(Vld), .H1(H1), .H2(H2), .B1(B1), .B2(B2), .P(P),
    .Busy(busy_b), .Done(done_b), .Pass(pass_b), .ErrCnt(err_b), .FirstFailVld(ffv_b),
    .FirstFailVec(ffvec_b), .CovMask(cov_b), .Signature(sig_b)
  );

  hw0_response_checker #(.NUM_VECTORS(40)) dut_sat (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Vld(Vld), .H1(H1), .H2(H2), .B1(B1), .B2(B2), .P(P),
    .Busy(busy_c), .Done(done_c), .Pass(pass_c), .ErrCnt(err_c), .FirstFailVld(ffv_c),
    .FirstFailVec(ffvec_c), .CovMask(cov_c), .Signature(sig_c)
  );

  typedef struct {
    logic [3:0] idx;
    logic       p;
    logic [4:0] exp_err;
    logic       exp_ffv;
    logic       exp_done;
  } vec_t;

  vec_t tbl[16];

  // Golden response written from the logic equation, independent of the hex table.
  function automatic logic golden(input logic [3:0] i);
    return (i[3] | i[2]) & (i[1] | i[0]);
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [3:0] i, input logic p);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {11'b0, i, p};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present inputs, wait for the edge, sample point is 1 ns later.
  task automatic drive(input logic s, input logic v, input logic [3:0] i, input logic p);
    Start = s;
    Vld   = v;
    {H1, H2, B1, B2} = i;
    P     = p;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    Vld   = 1'b0;
  endtask

  logic [15:0] sig_m;

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i].idx      = 4'(i);
      tbl[i].p        = golden(4'(i)) ^ ((i == 5) || (i == 12));
      tbl[i].exp_err  = (i < 5) ? 5'd0 : (i < 12) ? 5'd1 : 5'd2;
      tbl[i].exp_ffv  = (i >= 5);
      tbl[i].exp_done = (i == 15);
    end

    // Reset state
    #2;
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_err",  32'(err_a), 0);
    check("rst_cov",  32'(cov_a), 0);
    check("rst_sig",  32'(sig_a), 0);
    #10 Rst = 1'b0;

    // Full correct sweep
    drive(1, 0, 0, 0);
    check("sweep_busy_after_start", 32'(busy_a), 1);
    sig_m = 16'hFFFF;
    check("sweep_sig_seed", 32'(sig_a), SIG_EN ? 32'hFFFF : 32'h0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 4'(i), golden(4'(i)));
      sig_m = misr(sig_m, 4'(i), golden(4'(i)));
      if (i == 14) check("sweep_not_done_early", 32'(done_a), 0);
    end
    check("sweep_done",  32'(done_a), 1);
    check("sweep_busy",  32'(busy_a), 0);
    check("sweep_pass",  32'(pass_a), 1);
    check("sweep_err",   32'(err_a), 0);
    check("sweep_cov",   32'(cov_a), 32'hFFFF);
    check("sweep_ffv",   32'(ffv_a), 0);
    check("sweep_sig",   32'(sig_a), SIG_EN ? 32'(sig_m) : 32'h0);
    check("sweep_sat_still_busy", 32'(busy_c), 1);
    // Vld in DONE ignored; results hold
    drive(0, 1, 4'd7, ~golden(4'd7));
    check("done_hold_err",  32'(err_a), 0);
    check("done_hold_done", 32'(done_a), 1);
    check("done_hold_pass", 32'(pass_a), 1);
    check("done_hold_sig",  32'(sig_a), SIG_EN ? 32'(sig_m) : 32'h0);

    // Fault injection, table-driven
    drive(1, 0, 0, 0);
    check("fault_pass_cleared", 32'(pass_a), 0);
    check("fault_done_cleared", 32'(done_a), 0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, tbl[i].idx, tbl[i].p);
      check($sformatf("fault_err_%0d", i), 32'(err_a), 32'(tbl[i].exp_err));
      check($sformatf("fault_ffv_%0d", i), 32'(ffv_a), 32'(tbl[i].exp_ffv));
      check($sformatf("fault_done_%0d", i), 32'(done_a), 32'(tbl[i].exp_done));
    end
    check("fault_pass",  32'(pass_a), 0);
    check("fault_ffvec", 32'(ffvec_a), 5);

    // Coverage hole
    drive(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) drive(0, 1, 4'd0, 1'b0);
    check("hole_done",       32'(done_a), 1);
    check("hole_err",        32'(err_a), 0);
    check("hole_cov",        32'(cov_a), 32'h0001);
    check("hole_pass",       32'(pass_a), 0);
    check("hole_nocov_pass", 32'(pass_b), 1);

    // Restart and gaps
    drive(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 1, 4'(i), golden(4'(i)));
    check("restart_pre_cov", 32'(cov_a), 32'h007F);
    drive(1, 1, 4'd15, ~golden(4'd15));
    check("restart_cov",  32'(cov_a), 0);
    check("restart_err",  32'(err_a), 0);
    check("restart_busy", 32'(busy_a), 1);
    check("restart_sig",  32'(sig_a), SIG_EN ? 32'hFFFF : 32'h0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 4'(i), golden(4'(i)));
      if (i == 14) check("gap_not_done_15", 32'(done_a), 0);
      drive(0, 0, 4'(15 - i), ~golden(4'(15 - i)));
      if (i == 14) check("gap_still_busy", 32'(busy_a), 1);
    end
    check("gap_done", 32'(done_a), 1);
    check("gap_pass", 32'(pass_a), 1);
    check("gap_cov",  32'(cov_a), 32'hFFFF);

    // Saturation: 40 mismatching samples on the 40-sample instance
    drive(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      drive(0, 1, 4'(i % 16), ~golden(4'(i % 16)));
      if (i == 38) check("sat_not_done_39", 32'(done_c), 0);
    end
    check("sat_done",  32'(done_c), 1);
    check("sat_err",   32'(err_c), 31);
    check("sat_pass",  32'(pass_c), 0);
    check("sat_ffvec", 32'(ffvec_c), 0);
    check("sat_short_err", 32'(err_a), 16);

    // Async reset mid-run
    drive(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) drive(0, 1, 4'(i), golden(4'(i)) ^ (i == 3));
    check("arst_pre_err", 32'(err_a), 1);
    check("arst_pre_cov", 32'(cov_a), 32'h01FF);
    #2 Rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy_a), 0);
    check("arst_err",  32'(err_a), 0);
    check("arst_cov",  32'(cov_a), 0);
    check("arst_sig",  32'(sig_a), 0);
    check("arst_ffv",  32'(ffv_a), 0);
    #2 Rst = 1'b0;
    drive(0, 1, 4'd9, golden(4'd9));
    check("post_rst_busy", 32'(busy_a), 0);
    check("post_rst_cov",  32'(cov_a), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
